// File: rtl/char_frame_buf.sv
// char_frame_buf -- double-buffered character frame store for a text display.
//
// Writers fill a back buffer one character at a time, or clear it to spaces
// (0x20) in one cycle. A commit request publishes the back buffer to the
// front buffer at the next frame boundary (print_fin), so the display never
// shows a half-updated frame. dout is driven only by the front registers.
//
// Optional feature: define CHAR_FRAME_BUF_SCROLL_EN to add a one-cycle
// scroll-up of the back buffer (the last row is refilled with spaces).
//
// Ports:
//   clk            - single clock, rising edge
//   rst            - synchronous active-high reset (front/back -> 0x20, FSM idle)
//   we             - back-buffer write strobe
//   wr_addr        - character index, row*COLS + col
//   din            - character code to write
//   clr            - fill back buffer with 0x20
//   scroll         - (CHAR_FRAME_BUF_SCROLL_EN only) scroll back buffer up one row
//   commit         - request publish at the next frame boundary
//   print_fin      - frame-boundary pulse from the display controller
//   dout           - front buffer, character i at [i*CHAR_W +: CHAR_W]
//   commit_pending - commit accepted but not yet published
//   swap_done      - one-cycle pulse after the front buffer is updated
//   wr_err         - one-cycle pulse after an ignored out-of-range write
module char_frame_buf #(
  parameter int COLS   = 16,
  parameter int ROWS   = 4,
  parameter int CHAR_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            we,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [CHAR_W-1:0]               din,
  input  logic                            clr,
`ifdef CHAR_FRAME_BUF_SCROLL_EN
  input  logic                            scroll,
`endif
  input  logic                            commit,
  input  logic                            print_fin,
  output logic [ROWS*COLS*CHAR_W-1:0]     dout,
  output logic                            commit_pending,
  output logic                            swap_done,
  output logic                            wr_err
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CHAR_W-1:0] SPACE = CHAR_W'(32'h20);
  localparam logic [ADDR_W:0]   N_EXT = (ADDR_W + 1)'(N);

  typedef enum logic {IDLE, PEND} state_t;

  state_t            state;
  logic [CHAR_W-1:0] back  [N];
  logic [CHAR_W-1:0] front [N];

  logic              in_range;
  logic [IDX_W-1:0]  wr_idx;
  logic              write_blocked;
  logic              do_swap;

  assign in_range = ({1'b0, wr_addr} < N_EXT);
  assign wr_idx   = wr_addr[IDX_W-1:0];

  // Higher-priority back-buffer operations silently swallow a same-cycle write.
`ifdef CHAR_FRAME_BUF_SCROLL_EN
  assign write_blocked = clr | scroll;
`else
  assign write_blocked = clr;
`endif

  // A commit arriving together with print_fin publishes immediately.
  assign do_swap = print_fin & ((state == PEND) | commit);

  assign commit_pending = (state == PEND);

  // Control FSM and its registered pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      swap_done <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      swap_done <= do_swap;
      wr_err    <= we & ~in_range & ~write_blocked;
      case (state)
        IDLE:    if (commit && !print_fin) state <= PEND;
        PEND:    if (print_fin)            state <= IDLE;
        default:                           state <= IDLE;
      endcase
    end
  end

  // NOTE: both buffers are flop arrays (every entry is read in parallel by
  // dout and by the swap), so resetting every entry is legal and required;
  // a RAM-backed array could not be reset like this.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        back[i]  <= SPACE;
        front[i] <= SPACE;
      end
    end else begin
      // Front copies the pre-edge back contents; a same-cycle back update
      // is only seen on the following commit.
      if (do_swap) begin
        for (int i = 0; i < N; i++) front[i] <= back[i];
      end

      if (clr) begin
        for (int i = 0; i < N; i++) back[i] <= SPACE;
      end
`ifdef CHAR_FRAME_BUF_SCROLL_EN
      else if (scroll) begin
        for (int i = 0; i < N - COLS; i++) back[i] <= back[i + COLS];
        for (int i = N - COLS; i < N; i++) back[i] <= SPACE;
      end
`endif
      else if (we && in_range) begin
        back[wr_idx] <= din;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_dout
    assign dout[g*CHAR_W +: CHAR_W] = front[g];
  end

endmodule

// File: tb/tb_char_frame_buf.sv
// Self-checking bench for char_frame_buf (COLS=16, ROWS=4, CHAR_W=8, ADDR_W=7
// so that out-of-range index 64 is representable). A table of directed steps
// with explicit expected values is followed by random traffic compared
// against a behavioural model of the frame store.
module tb_char_frame_buf;

  localparam int COLS = 16;
  localparam int ROWS = 4;
  localparam int CW   = 8;
  localparam int AW   = 7;
  localparam int N    = ROWS * COLS;
  localparam int DW   = N * CW;

  logic          clk = 1'b0;
  logic          rst, we, clr, commit, print_fin, scroll;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] din;
  logic [DW-1:0] dout;
  logic          commit_pending, swap_done, wr_err;

  always #5 clk = ~clk;

  char_frame_buf #(.COLS(COLS), .ROWS(ROWS), .CHAR_W(CW), .ADDR_W(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .we             (we),
    .wr_addr        (wr_addr),
    .din            (din),
    .clr            (clr),
`ifdef CHAR_FRAME_BUF_SCROLL_EN
    .scroll         (scroll),
`endif
    .commit         (commit),
    .print_fin      (print_fin),
    .dout           (dout),
    .commit_pending (commit_pending),
    .swap_done      (swap_done),
    .wr_err         (wr_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [CW-1:0] m_back [N];
  logic [CW-1:0] m_front[N];
  bit m_pend, m_swap, m_err;

  function automatic logic [DW-1:0] model_dout();
    logic [DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*CW +: CW] = m_front[i];
    return v;
  endfunction

  // Expected state after the edge that samples the given inputs.
  task automatic model_step(input bit r, input bit w, input int a, input logic [CW-1:0] d,
                            input bit c, input bit s, input bit cm, input bit pf);
    logic [CW-1:0] old_back[N];
    bit publish;
    if (r) begin
      for (int i = 0; i < N; i++) begin m_back[i] = 8'h20; m_front[i] = 8'h20; end
      m_pend = 0; m_swap = 0; m_err = 0;
      return;
    end
    old_back = m_back;
    publish  = pf && (m_pend || cm);
    if (publish) m_front = old_back;
    m_swap = publish;
    m_pend = m_pend ? !pf : (cm && !pf);
    m_err  = w && (a >= N) && !c && !s;
    if (c)
      for (int i = 0; i < N; i++) m_back[i] = 8'h20;
    else if (s)
      for (int i = 0; i < N; i++) m_back[i] = (i < N - COLS) ? old_back[i + COLS] : 8'h20;
    else if (w && a < N)
      m_back[a] = d;
  endtask

  // Drive one cycle of inputs, advance the model, and compare after the edge.
  task automatic apply(input string tag, input bit r, input bit w, input int a,
                       input logic [CW-1:0] d, input bit c, input bit s,
                       input bit cm, input bit pf);
    @(negedge clk);
    rst = r; we = w; wr_addr = AW'(a); din = d; clr = c; scroll = s;
    commit = cm; print_fin = pf;
    model_step(r, w, a, d, c, s, cm, pf);
    @(posedge clk);
    #1;
    check({tag, " dout"}, dout, model_dout());
  endtask

  function automatic logic [CW-1:0] ch(input int idx);
    return dout[idx*CW +: CW];
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    bit rst, we; int addr; logic [CW-1:0] din; bit clr, commit, pf;
    bit exp_pend, exp_swap, exp_err; int chk_idx; logic [CW-1:0] exp_char;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit w, int a, logic [CW-1:0] d, bit c, bit cm, bit pf,
                              bit ep, bit es, bit ee, int ci, logic [CW-1:0] ec);
    vec_t v;
    v.rst = r; v.we = w; v.addr = a; v.din = d; v.clr = c; v.commit = cm; v.pf = pf;
    v.exp_pend = ep; v.exp_swap = es; v.exp_err = ee; v.chk_idx = ci; v.exp_char = ec;
    return v;
  endfunction

  initial begin
    rst = 1; we = 0; wr_addr = '0; din = '0; clr = 0; commit = 0; print_fin = 0; scroll = 0;
    for (int i = 0; i < N; i++) begin m_back[i] = 8'h20; m_front[i] = 8'h20; end

    //              rst we addr din   clr cm pf | pend swap err idx char
    // reset, write 0x41@0, commit, print_fin three cycles later
    tbl.push_back(mk(1, 0,  0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 8'h20));
    tbl.push_back(mk(0, 1,  0, 8'h41, 0, 0, 0,   0, 0, 0, 0, 8'h20));
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 1, 0,   1, 0, 0, 0, 8'h20));
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 0, 0,   1, 0, 0, 0, 8'h20));
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 0, 0,   1, 0, 0, 0, 8'h20));
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 0, 1,   0, 1, 0, 0, 8'h41));
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 8'h41));
    // write without commit: print_fin leaves front alone
    tbl.push_back(mk(0, 1,  5, 8'h42, 0, 0, 0,   0, 0, 0, 5, 8'h20));
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 0, 1,   0, 0, 0, 5, 8'h20));
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 0, 0,   0, 0, 0, 5, 8'h20));
    // out-of-range write, then commit+print_fin together
    tbl.push_back(mk(0, 1, 64, 8'h55, 0, 0, 0,   0, 0, 1, 0, 8'h41));
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 8'h41));
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 1, 1,   0, 1, 0, 0, 8'h41));
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 0, 0,   0, 0, 0, 5, 8'h42));
    // clr beats a same-cycle write, no wr_err
    tbl.push_back(mk(0, 1,  2, 8'h43, 1, 0, 0,   0, 0, 0, 2, 8'h20));
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 1, 0,   1, 0, 0, 0, 8'h41));
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 0, 1,   0, 1, 0, 2, 8'h20));
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 0, 0,   0, 0, 0, 0, 8'h20));
    // reset discards a pending commit
    tbl.push_back(mk(0, 1,  3, 8'h44, 0, 0, 0,   0, 0, 0, 3, 8'h20));
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 1, 0,   1, 0, 0, 3, 8'h20));
    tbl.push_back(mk(1, 0,  0, 8'h00, 0, 0, 0,   0, 0, 0, 3, 8'h20));
    tbl.push_back(mk(0, 1,  3, 8'h44, 0, 0, 0,   0, 0, 0, 3, 8'h20));
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 0, 1,   0, 0, 0, 3, 8'h20));
    // redundant commit while pending gives a single swap
    tbl.push_back(mk(0, 1,  1, 8'h46, 0, 0, 0,   0, 0, 0, 1, 8'h20));
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 1, 0,   1, 0, 0, 1, 8'h20));
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 1, 0,   1, 0, 0, 1, 8'h20));
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 0, 1,   0, 1, 0, 1, 8'h46));
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 0, 0,   0, 0, 0, 1, 8'h46));
    // write in the swap cycle lands in back only, published next time
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 1, 0,   1, 0, 0, 7, 8'h20));
    tbl.push_back(mk(0, 1,  7, 8'h47, 0, 0, 1,   0, 1, 0, 7, 8'h20));
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 1, 1,   0, 1, 0, 7, 8'h47));
    tbl.push_back(mk(0, 0,  0, 8'h00, 0, 0, 0,   0, 0, 0, 3, 8'h44));

    for (int k = 0; k < tbl.size(); k++) begin
      string tag;
      tag = $sformatf("vec%0d", k);
      apply(tag, tbl[k].rst, tbl[k].we, tbl[k].addr, tbl[k].din, tbl[k].clr, 1'b0,
            tbl[k].commit, tbl[k].pf);
      check({tag, " commit_pending"}, DW'(commit_pending), DW'(tbl[k].exp_pend));
      check({tag, " swap_done"},      DW'(swap_done),      DW'(tbl[k].exp_swap));
      check({tag, " wr_err"},         DW'(wr_err),         DW'(tbl[k].exp_err));
      check({tag, " char"},           DW'(ch(tbl[k].chk_idx)), DW'(tbl[k].exp_char));
    end

`ifdef CHAR_FRAME_BUF_SCROLL_EN
    // Row 1 filled with '1', scroll, publish: row 0 = '1', row 3 = spaces.
    apply("scr_rst", 1, 0, 0, 8'h00, 0, 0, 0, 0);
    for (int c = 0; c < COLS; c++) apply("scr_fill", 0, 1, COLS + c, 8'h31, 0, 0, 0, 0);
    apply("scr_sc", 0, 1, 4, 8'h77, 0, 1, 0, 0);
    check("scroll drops write wr_err", DW'(wr_err), DW'(0));
    apply("scr_cm", 0, 0, 0, 8'h00, 0, 0, 1, 0);
    apply("scr_pf", 0, 0, 0, 8'h00, 0, 0, 0, 1);
    check("scroll row0", DW'(ch(0)), DW'(8'h31));
    check("scroll row0 end", DW'(ch(COLS - 1)), DW'(8'h31));
    check("scroll row3", DW'(ch(N - 1)), DW'(8'h20));
`endif

    // ---------------- randomized traffic vs model ----------------
    for (int k = 0; k < 400; k++) begin
      bit r, w, c, s, cm, pf;
      int a;
      logic [CW-1:0] d;
      r  = ($urandom_range(0, 63) == 0);
      c  = ($urandom_range(0, 15) == 0);
`ifdef CHAR_FRAME_BUF_SCROLL_EN
      s  = ($urandom_range(0, 15) == 0);
`else
      s  = 0;
`endif
      w  = $urandom_range(0, 1) == 1;
      a  = $urandom_range(0, 79);
      d  = CW'($urandom);
      cm = ($urandom_range(0, 5) == 0);
      pf = ($urandom_range(0, 4) == 0);
      apply($sformatf("rnd%0d", k), r, w, a, d, c, s, cm, pf);
      check($sformatf("rnd%0d commit_pending", k), DW'(commit_pending), DW'(m_pend));
      check($sformatf("rnd%0d swap_done", k),      DW'(swap_done),      DW'(m_swap));
      check($sformatf("rnd%0d wr_err", k),         DW'(wr_err),         DW'(m_err));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/char_frame_buf.md
CHAR_FRAME_BUF -- requirements
Module: char_frame_buf

Interface
REQ-001 SHALL have parameter COLS, default 16, characters per row.
REQ-002 SHALL have parameter ROWS, default 4, rows per frame; N = ROWS*COLS.
REQ-003 SHALL have parameter CHAR_W, default 8, bits per character code.
REQ-004 SHALL have parameter ADDR_W, default 6, write-address width; 2**ADDR_W >= N is required.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-007 SHALL have port we, input, 1, back-buffer write strobe.
REQ-008 SHALL have port wr_addr, input, ADDR_W, character index (row*COLS + col).
REQ-009 SHALL have port din, input, CHAR_W, character code to write.
REQ-010 SHALL have port clr, input, 1, one-cycle request to fill the back buffer with 0x20.
REQ-011 SHALL have port commit, input, 1, one-cycle request to publish the back buffer at the next frame boundary.
REQ-012 SHALL have port print_fin, input, 1, one-cycle pulse from the display controller marking the frame boundary.
REQ-013 SHALL have port dout, output, N*CHAR_W, front buffer; character i at bits [i*CHAR_W +: CHAR_W].
REQ-014 SHALL have port commit_pending, output, 1, commit accepted but not yet published.
REQ-015 SHALL have port swap_done, output, 1, one-cycle pulse when front is updated.
REQ-016 SHALL have port wr_err, output, 1, one-cycle pulse on an ignored out-of-range write.

Function
REQ-017 SHALL hold two N-entry arrays: back (written) and front (driving dout, registered, never written directly).
REQ-018 SHALL, on we with wr_addr < N, write din to back[wr_addr] at that edge; visible in back the next cycle.
REQ-019 SHALL ignore we with wr_addr >= N, leave back unchanged, and pulse wr_err the next cycle.
REQ-020 SHALL, on clr, set every back entry to 0x20 (CHAR_W-bit zero-extended) in one cycle.
REQ-021 SHALL apply per-cycle back-buffer priority clr > scroll (when compiled in) > we; a lower-priority write in the same cycle is dropped without wr_err.
REQ-022 SHALL run a 2-state FSM: IDLE (commit_pending=0) and PEND (commit_pending=1).
REQ-023 SHALL, in IDLE with commit=1 and print_fin=0, go to PEND.
REQ-024 SHALL, in IDLE with commit=1 and print_fin=1 in the same cycle, copy back to front at that edge, stay IDLE, and pulse swap_done the next cycle.
REQ-025 SHALL, in PEND on print_fin=1, copy back to front, return to IDLE, and pulse swap_done the next cycle.
REQ-026 SHALL treat commit in PEND as redundant (no extra swap).
REQ-027 SHALL copy the back contents registered before the edge; a write/clr/scroll in the swap cycle lands in back only and is published on the next commit.
REQ-028 SHALL leave front unchanged on print_fin in IDLE without commit.
REQ-029 SHALL drive dout directly from front registers, with no combinational path from inputs.

Reset
REQ-030 SHALL, on rst=1 at an edge, set all front and back entries to 0x20, set FSM to IDLE, and set commit_pending, swap_done and wr_err to 0.
REQ-031 SHALL give rst priority over every other input; a pending commit is discarded.

Configuration
REQ-032 SHALL, when macro CHAR_FRAME_BUF_SCROLL_EN is defined, add input port scroll (1 bit).
REQ-033 SHALL, on scroll, set back[i] = back[i+COLS] for i < N-COLS and fill the last row with 0x20 in one cycle.
REQ-034 SHALL, without CHAR_FRAME_BUF_SCROLL_EN, have no scroll port and no scroll logic; all else identical.

Verification
REQ-035 SHALL check: reset, then write 0x41 at addr 0, commit, print_fin 3 cycles later -> dout[7:0]=0x41 after the print_fin edge, swap_done one pulse, commit_pending high for 3 cycles.
REQ-036 SHALL check: write 0x42 at addr 5 with no commit, print_fin -> dout char 5 stays 0x20, no swap_done.
REQ-037 SHALL check: write addr 64 (N=64) -> wr_err pulse, back unchanged; commit plus print_fin in the same cycle -> immediate swap, commit_pending never set.
REQ-038 SHALL check: clr and we 0x43 @ addr 2 in the same cycle, commit, print_fin -> char 2 = 0x20, no wr_err.
REQ-039 SHALL check with CHAR_FRAME_BUF_SCROLL_EN: fill row1 with 0x31, scroll, commit, print_fin -> row0 = 0x31, row3 = 0x20.
REQ-040 SHALL check: commit, rst before print_fin -> commit_pending=0 and the later print_fin causes no swap.
